// File: rtl/filtro_banco_tdm_if.sv
// Sample, coefficient-write and result bus of the time-multiplexed biquad filter bank.
interface filtro_banco_tdm_if #(
  parameter int Width = 25,
  parameter int Bands = 3,
  parameter int AW    = 8
);
  logic                     enable;
  logic signed [Width-1:0]  uk;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [Width-1:0]  coef_data;
  logic [Bands*Width-1:0]   yk;
  logic                     yk_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output enable, uk, coef_we, coef_addr, coef_data,
    input  yk, yk_valid, busy, overrun
  );

  modport slave (
    input  enable, uk, coef_we, coef_addr, coef_data,
    output yk, yk_valid, busy, overrun
  );
endinterface

// File: rtl/filtro_banco_tdm.sv
// Bands x Sections cascaded DF-I biquads sharing one MAC, one product per clock.
// Define FILTRO_BANCO_SAT_EN to clamp section results instead of wrapping them.
module filtro_banco_tdm #(
  parameter int Width     = 25,
  parameter int Presicion = 16,
  parameter int Bands     = 3,
  parameter int Sections  = 2,
  parameter int AW        = 8
) (
  input  logic             clock,
  input  logic             reset,
  filtro_banco_tdm_if.slave bus
);
  localparam int NSEC = Bands * Sections;
  localparam int ACCW = 2 * Width + 3;
  localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int BW   = (Bands > 1) ? $clog2(Bands) : 1;
  localparam int SBW  = (Sections > 1) ? $clog2(Sections) : 1;

  localparam logic signed [Width-1:0] ONE   = {{(Width-1){1'b0}}, 1'b1} << Presicion;
  localparam logic signed [ACCW-1:0]  ROUND = {{(ACCW-1){1'b0}}, 1'b1} << (Presicion - 1);
  localparam logic [AW-4:0]           NSEC_A = (AW-3)'(NSEC);

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t                   state_reg;
  logic [SW-1:0]            sec_reg;
  logic [BW-1:0]            band_reg;
  logic [SBW-1:0]           sub_reg;
  logic [2:0]               idx_reg;
  logic signed [ACCW-1:0]   acc_reg;
  logic signed [Width-1:0]  x_reg;
  logic signed [Width-1:0]  in_reg;
  logic signed [Width-1:0]  coef_reg [NSEC][5];
  logic signed [Width-1:0]  x1_reg [NSEC];
  logic signed [Width-1:0]  x2_reg [NSEC];
  logic signed [Width-1:0]  y1_reg [NSEC];
  logic signed [Width-1:0]  y2_reg [NSEC];
  logic signed [Width-1:0]  band_out_reg [Bands];
  logic signed [Width-1:0]  yk_reg [Bands];
  logic                     yk_valid_reg;
  logic                     busy_reg;
  logic                     overrun_reg;

  logic signed [Width-1:0]   operand;
  logic signed [Width-1:0]   coef_sel;
  logic signed [2*Width-1:0] prod;
  logic signed [ACCW-1:0]    prod_ext;
  logic signed [ACCW-1:0]    rnd_sum;
  logic signed [ACCW-1:0]    rnd_shift;
  logic signed [Width-1:0]   y_res;
  logic [AW-4:0]             wsec;
  logic [2:0]                widx;
  logic                      coef_wr;

  // Operand order matches coefficient order: b0..b2 on inputs, a1..a2 on outputs.
  always_comb begin
    operand = x_reg;
    case (idx_reg)
      3'd1:    operand = x1_reg[sec_reg];
      3'd2:    operand = x2_reg[sec_reg];
      3'd3:    operand = y1_reg[sec_reg];
      3'd4:    operand = y2_reg[sec_reg];
      default: operand = x_reg;
    endcase
  end

  assign coef_sel  = coef_reg[sec_reg][idx_reg];
  assign prod      = (2*Width)'(coef_sel) * (2*Width)'(operand);
  assign prod_ext  = ACCW'(prod);
  assign rnd_sum   = acc_reg + ROUND;
  assign rnd_shift = rnd_sum >>> Presicion;

`ifdef FILTRO_BANCO_SAT_EN
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-Width+1){1'b1}}, {(Width-1){1'b0}}};

  always_comb begin
    if (rnd_shift > MAXV)      y_res = MAXV[Width-1:0];
    else if (rnd_shift < MINV) y_res = MINV[Width-1:0];
    else                       y_res = rnd_shift[Width-1:0];
  end
`else
  logic unused_bits;
  assign y_res       = rnd_shift[Width-1:0];
  assign unused_bits = ^rnd_shift[ACCW-1:Width];
`endif

  assign wsec    = bus.coef_addr[AW-1:3];
  assign widx    = bus.coef_addr[2:0];
  assign coef_wr = bus.coef_we && !busy_reg && (widx < 3'd5) && (wsec < NSEC_A);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      sec_reg      <= '0;
      band_reg     <= '0;
      sub_reg      <= '0;
      idx_reg      <= '0;
      acc_reg      <= '0;
      x_reg        <= '0;
      in_reg       <= '0;
      yk_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        for (int j = 0; j < 5; j++) coef_reg[i][j] <= (j == 0) ? ONE : '0;
        x1_reg[i] <= '0;
        x2_reg[i] <= '0;
        y1_reg[i] <= '0;
        y2_reg[i] <= '0;
      end
      for (int b = 0; b < Bands; b++) begin
        band_out_reg[b] <= '0;
        yk_reg[b]       <= '0;
      end
    end else begin
      yk_valid_reg <= 1'b0;
      if (bus.enable && busy_reg) overrun_reg <= 1'b1;
      if (coef_wr) coef_reg[wsec[SW-1:0]][widx] <= bus.coef_data;

      case (state_reg)
        IDLE: begin
          if (bus.enable) begin
            x_reg     <= bus.uk;
            in_reg    <= bus.uk;
            sec_reg   <= '0;
            band_reg  <= '0;
            sub_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (idx_reg == 3'd0)     acc_reg <= prod_ext;
          else if (idx_reg < 3'd3) acc_reg <= acc_reg + prod_ext;
          else                     acc_reg <= acc_reg - prod_ext;
          if (idx_reg == 3'd4) begin
            idx_reg   <= '0;
            state_reg <= WB;
          end else begin
            idx_reg <= idx_reg + 3'd1;
          end
        end
        WB: begin
          x2_reg[sec_reg] <= x1_reg[sec_reg];
          x1_reg[sec_reg] <= x_reg;
          y2_reg[sec_reg] <= y1_reg[sec_reg];
          y1_reg[sec_reg] <= y_res;
          sec_reg         <= sec_reg + SW'(1);
          if (sub_reg == SBW'(Sections - 1)) begin
            // Last section of this band: restart the cascade from the captured sample.
            band_out_reg[band_reg] <= y_res;
            x_reg                  <= in_reg;
            sub_reg                <= '0;
            if (band_reg == BW'(Bands - 1)) begin
              state_reg <= DONE;
            end else begin
              band_reg  <= band_reg + BW'(1);
              state_reg <= MAC;
            end
          end else begin
            x_reg     <= y_res;
            sub_reg   <= sub_reg + SBW'(1);
            state_reg <= MAC;
          end
        end
        DONE: begin
          for (int b = 0; b < Bands; b++) yk_reg[b] <= band_out_reg[b];
          yk_valid_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Bands; gi++) begin : g_yk
      assign bus.yk[gi*Width +: Width] = yk_reg[gi];
    end
  endgenerate

  assign bus.yk_valid = yk_valid_reg;
  assign bus.busy     = busy_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_filtro_banco_tdm.sv
// Bench for filtro_banco_tdm: identity table, test-plan sequences, then random coefficients and samples against an arithmetic model.
module tb_filtro_banco_tdm;
  localparam int W  = 25;
  localparam int NB = 3;
  localparam int NS = 2;
  localparam longint MAXV = 64'sd16777215;
  localparam longint MINV = -64'sd16777216;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  filtro_banco_tdm_if #(.Width(W), .Bands(NB), .AW(8)) bus ();

  filtro_banco_tdm #(.Width(W), .Presicion(16), .Bands(NB), .Sections(NS), .AW(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    longint u;
    longint e0;
    longint e1;
    longint e2;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int pulses;
  vec_t tbl[6];

  longint m_coef[NB][NS][5];
  longint m_x1[NB][NS];
  longint m_x2[NB][NS];
  longint m_y1[NB][NS];
  longint m_y2[NB][NS];
  longint m_out[NB];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic longint band_val(input int b);
    logic signed [W-1:0] v;
    v = bus.yk[b*W +: W];
    return longint'(v);
  endfunction

  function automatic longint band_raw(input int b);
    logic [W-1:0] r;
    r = bus.yk[b*W +: W];
    return longint'(r);
  endfunction

  task automatic check_bands(input string tag, input longint e0, input longint e1, input longint e2);
    $display("%s: yk = %0d %0d %0d (want %0d %0d %0d)", tag, band_val(0), band_val(1), band_val(2), e0, e1, e2);
    chk({tag, "_band0"}, band_val(0), e0);
    chk({tag, "_band1"}, band_val(1), e1);
    chk({tag, "_band2"}, band_val(2), e2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.coef_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", bus.yk_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    for (int b = 0; b < NB; b++) chk("rst_yk", band_val(b), 0);
  endtask

  task automatic write_coef(input int b, input int s, input int i, input longint v);
    bus.coef_addr = 8'((b*NS + s)*8 + i);
    bus.coef_data = 25'(v);
    bus.coef_we = 1'b1;
    tick();
    bus.coef_we = 1'b0;
  endtask

  // Enable lands in cycle 0; result expected after exactly 38 cycles.
  task automatic run_sample(input longint u, input string tag);
    bus.uk = 25'(u);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.coef_we = 1'b0;
    lat = 1;
    chk({tag, "_busy_c1"}, bus.busy, 1);
    while (!bus.yk_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 38);
    chk({tag, "_busy_cL"}, bus.busy, 0);
  endtask

  function automatic longint reduce(input longint v);
`ifdef FILTRO_BANCO_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < 5; i++) m_coef[b][s][i] = (i == 0) ? 64'sd65536 : 64'sd0;
        m_x1[b][s] = 0; m_x2[b][s] = 0; m_y1[b][s] = 0; m_y2[b][s] = 0;
      end
  endtask

  task automatic model_sample(input longint u);
    longint x, acc, y;
    for (int b = 0; b < NB; b++) begin
      x = u;
      for (int s = 0; s < NS; s++) begin
        acc = m_coef[b][s][0]*x + m_coef[b][s][1]*m_x1[b][s] + m_coef[b][s][2]*m_x2[b][s]
            - m_coef[b][s][3]*m_y1[b][s] - m_coef[b][s][4]*m_y2[b][s];
        y = reduce((acc + 64'sd32768) >>> 16);
        m_x2[b][s] = m_x1[b][s]; m_x1[b][s] = x;
        m_y2[b][s] = m_y1[b][s]; m_y1[b][s] = y;
        x = y;
      end
      m_out[b] = x;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint u, v;
    int nb, nw, ns, ni;
    longint sat_exp;

    bus.enable = 1'b0;
    bus.uk = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    tbl[0] = '{u: 1000,      e0: 1000,      e1: 1000,      e2: 1000};
    tbl[1] = '{u: -1000,     e0: -1000,     e1: -1000,     e2: -1000};
    tbl[2] = '{u: 0,         e0: 0,         e1: 0,         e2: 0};
    tbl[3] = '{u: MAXV,      e0: MAXV,      e1: MAXV,      e2: MAXV};
    tbl[4] = '{u: MINV,      e0: MINV,      e1: MINV,      e2: MINV};
    tbl[5] = '{u: 1,         e0: 1,         e1: 1,         e2: 1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_sample(tbl[i].u, "ident");
      check_bands("ident", tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    // 0.5 gain on band 1 section 0; -1001 exercises round-half-up on a negative value.
    write_coef(1, 0, 0, 64'sh8000);
    run_sample(1000, "gain");
    check_bands("gain", 1000, 500, 1000);
    run_sample(1001, "gain");
    check_bands("gain", 1001, 501, 1001);
    run_sample(-1001, "gain");
    check_bands("gain", -1001, -500, -1001);

    bus.coef_addr = 8'((1*NS + 1)*8);
    bus.coef_data = 25'h08000;
    bus.coef_we = 1'b1;
    run_sample(1000, "samecyc");
    check_bands("samecyc", 1000, 250, 1000);

    do_reset();
    write_coef(0, 0, 3, -64'sd32768);
    run_sample(1024, "recur");
    check_bands("recur", 1024, 1024, 1024);
    run_sample(0, "recur");
    check_bands("recur", 512, 0, 0);
    run_sample(0, "recur");
    check_bands("recur", 256, 0, 0);

    do_reset();
    write_coef(2, 0, 0, 64'sh20000);
    run_sample(64'sh0FFFFFF, "sat");
`ifdef FILTRO_BANCO_SAT_EN
    sat_exp = 64'sh0FFFFFF;
`else
    sat_exp = 64'sh1FFFFFE;
`endif
    $display("sat: band2 raw = 0x%0h (want 0x%0h)", band_raw(2), sat_exp);
    chk("sat_band2", band_raw(2), sat_exp);
    chk("sat_band0", band_raw(0), 64'sh0FFFFFF);
    chk("sat_band1", band_raw(1), 64'sh0FFFFFF);

    // Second enable at cycle 10 and a write at cycle 12 must both be ignored.
    do_reset();
    bus.uk = 25'd500;
    bus.enable = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      bus.enable = (lat == 10);
      bus.uk = (lat == 10) ? 25'd77 : 25'd500;
      bus.coef_we = (lat == 12);
      bus.coef_addr = 8'd0;
      bus.coef_data = 25'h08000;
    end while (!bus.yk_valid && lat < 60);
    bus.coef_we = 1'b0;
    chk("ovr_latency", lat, 38);
    chk("ovr_flag", bus.overrun, 1);
    check_bands("ovr", 500, 500, 500);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.yk_valid) pulses++;
    end
    chk("ovr_extra_pulses", pulses, 0);
    run_sample(300, "ovr_coef");
    check_bands("ovr_coef", 300, 300, 300);
    chk("ovr_sticky", bus.overrun, 1);

    // Reset during cycle 20 must abort the sample and restore identity coefficients.
    write_coef(1, 1, 0, 64'sh8000);
    bus.uk = 25'd900;
    bus.enable = 1'b1;
    lat = 0;
    pulses = 0;
    while (lat < 60) begin
      tick();
      lat++;
      bus.enable = 1'b0;
      reset = (lat == 20);
      if (bus.yk_valid) pulses++;
    end
    reset = 1'b0;
    chk("midrst_pulses", pulses, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_overrun", bus.overrun, 0);
    check_bands("midrst_yk", 0, 0, 0);
    run_sample(1000, "midrst_next");
    check_bands("midrst_next", 1000, 1000, 1000);

    do_reset();
    model_reset();
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        nb = $urandom_range(0, NB-1);
        ns = $urandom_range(0, NS-1);
        ni = $urandom_range(0, 7);
        v  = longint'($urandom_range(0, 262143)) - 64'sd131072;
        write_coef(nb, ns, ni, v);
        if (ni < 5) m_coef[nb][ns][ni] = v;
      end
      u = longint'($urandom_range(0, 33554431)) - 64'sd16777216;
      if (it % 4 == 0) u = u >>> 12;
      model_sample(u);
      run_sample(u, "rand");
      check_bands("rand", m_out[0], m_out[1], m_out[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filtro_banco_tdm.md
# filtro_banco_tdm

Parametrised, time-multiplexed multi-band IIR filter bank for the audio equaliser path. It replaces a fixed set of hard-wired biquad instances with one shared multiply-accumulate datapath. That datapath runs on a fast system clock and serves Bands × Sections cascaded biquads. Coefficients are held in runtime-writable storage, and saturation is selectable at compile time. It sits between the audio sample source and the per-band gain/mix stage.

## Interface
- Width, 25: sample and coefficient word width, signed two's complement.
- Presicion, 16: fractional bits of the Q format; Magnitud = Width-Presicion-1.
- Bands, 3: number of parallel bands, all fed from the same input.
- Sections, 2: number of cascaded biquads per band.
- AW, 8: coefficient address width; must satisfy 2^AW ≥ Bands*Sections*8.
- clock  in  1  system clock; minimum frequency is L × sample rate.
- reset  in  1  synchronous, active-high.
- enable  in  1  sample strobe; one-cycle pulse; uk is valid in the same cycle.
- uk  in  Width  input sample, signed.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  address = (band*Sections+section)*8 + idx, where idx 0..4 = b0,b1,b2,a1,a2 and idx 5..7 is ignored.
- coef_data  in  Width  coefficient value in Q(Magnitud).(Presicion).
- yk  out  Bands*Width  band b output at yk[(b+1)*Width-1 : b*Width].
- yk_valid  out  1  one-cycle pulse when yk updates.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  sticky flag; cleared only by reset.

## Operation
- Per section: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2 (Direct Form I). Section 0 takes x = uk; section s>0 takes the current output of section s−1 in the same band.
- Per-section state is x1, x2, y1, y2. It is updated at writeback: x2←x1, x1←x, y2←y1, y1←y.
- FSM states:
  - IDLE: on enable, capture uk and go to MAC.
  - MAC: 5 cycles, one product per cycle in order b0, b1, b2, a1, a2, then go to WB.
  - WB: 1 cycle; round, saturate, update state. Go to the next section (then the next band) in MAC, or to DONE after the last one.
  - DONE: 1 cycle; drive yk, pulse yk_valid, return to IDLE.
- Arithmetic:
  - Products are 2·Width bits; the accumulator is 2·Width+3 bits.
  - Result = (acc + 2^(Presicion−1)) >>> Presicion, i.e. round half up.
  - The result is then reduced to Width bits per the Configuration section.
- Reset:
  - Clears all section state and sets yk=0, yk_valid=0, busy=0, overrun=0, FSM=IDLE.
  - Loads identity coefficients everywhere: b0=2^Presicion, all others 0.
- Reset mid-sample aborts the computation: no yk_valid is produced, and all state and coefficients return to their reset values.
- enable while busy=1: the sample is dropped, overrun is set to 1, and the computation continues unaffected.
- coef_we while busy=1: the write is ignored. coef_we with busy=0 writes on that edge.
- coef_we and enable in the same cycle with busy=0: the write lands first, so the new coefficient is used for that sample.

## Timing
- Cycle 0 is the cycle where enable is high with FSM in IDLE.
- busy is high from cycle 1 through cycle L−1, where L = Bands*Sections*6 + 2 (38 at defaults).
- yk and yk_valid update at cycle L. busy is low in cycle L, so a new enable is accepted in cycle L.
- yk holds its value between pulses.
- Minimum clock = L × fs: 38 × 44.1 kHz ≈ 1.68 MHz at defaults.

## Configuration
- FILTRO_BANCO_SAT_EN defined: the rounded result is clamped to [−2^(Width−1), 2^(Width−1)−1]. This applies at every WB, so the stored y1/y2 are the clamped values.
- FILTRO_BANCO_SAT_EN undefined: the rounded result is truncated to its low Width bits, so it wraps.

## Test plan
- Identity after reset: enable with uk=1000 → at cycle 38, yk_valid=1 and all three bands =1000. uk=−1000 → −1000.
- Gain: write b0=0x08000 (0.5) to band 1 section 0 only, then uk=1000 → band1=500 and bands 0 and 2 =1000.
- Recursion: band 0 section 0 set to a1=−0.5 (−0x08000), band 0 section 1 identity. Impulse uk=1024 then 0,0 → band0 = 1024, 512, 256.
- Saturation: b0=0x20000 (2.0) on band 2 section 0, uk=0x0FFFFFF:
  - with FILTRO_BANCO_SAT_EN → band2=0x0FFFFFF;
  - without it → band2=0x1FFFFFE.
- Overrun and ignored write: enable at cycle 0 and again at cycle 10, plus coef_we at cycle 12 → one yk_valid at cycle 38, overrun=1, and the coefficient is unchanged.
- Reset at cycle 20 of a sample → no yk_valid; yk=0, busy=0, overrun=0. The next sample gives the identity output.
